// File: rtl/ilb_pixel_sequencer.sv
// rtl/ilb_pixel_sequencer.sv - per-pixel ILB transaction sequencer with window/raster tracking
module ilb_pixel_sequencer #(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28,
    parameter int KERNEL     = 3,
    parameter int IDX_W      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_soft_clear,
    input  logic             i_uart_valid,
    input  logic [7:0]       i_uart_byte_in,
    output logic [7:0]       o_seq_byte,
    output logic             o_ilb_send_enable,
    input  logic             i_bytes_recieved,
    output logic             o_win_shift,
    output logic             o_conv_req,
    input  logic             i_conv_ack,
    output logic [IDX_W-1:0] o_col_idx,
    output logic [IDX_W-1:0] o_row_idx,
    output logic             o_frame_done,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(IMG_WIDTH - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(IMG_HEIGHT - 1);
    localparam logic [IDX_W-1:0] WIN_MIN  = IDX_W'(KERNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ILB,
        S_SHIFT,
        S_CONV_REQ,
        S_ADVANCE
    } state_t;

    state_t     r_state;
    logic [7:0] r_pend_byte;
    logic       r_pend_vld;
    logic       r_br_sync;
    logic       r_br_dly;

    logic w_consume;
    logic w_br_rise;
    logic w_clear;
    logic w_win_ok;
    logic w_frame_end;

    assign w_consume   = (r_state == S_ISSUE);
    assign w_br_rise   = r_br_sync & ~r_br_dly;
    assign w_clear     = (r_state == S_IDLE) & ~r_pend_vld & i_soft_clear;
    assign w_win_ok    = (o_row_idx >= WIN_MIN) && (o_col_idx >= WIN_MIN);
    assign w_frame_end = (o_col_idx == COL_LAST) && (o_row_idx == ROW_LAST);

    // One-deep holding register; the ISSUE cycle frees the slot so a byte arriving then is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_byte <= 8'd0;
            r_pend_vld  <= 1'b0;
            o_overrun   <= 1'b0;
            r_br_sync   <= 1'b0;
            r_br_dly    <= 1'b0;
        end else begin
            r_br_sync <= i_bytes_recieved;
            r_br_dly  <= r_br_sync;
            if (i_uart_valid) begin
                if (!r_pend_vld || w_consume) begin
                    r_pend_byte <= i_uart_byte_in;
                    r_pend_vld  <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (w_consume) begin
                r_pend_vld <= 1'b0;
            end
            if (w_clear) begin
                o_overrun <= 1'b0;
            end
        end
    end

    // Strobes are registered on entry to the state they belong to, so they line up with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state           <= S_IDLE;
            o_seq_byte        <= 8'd0;
            o_ilb_send_enable <= 1'b0;
            o_win_shift       <= 1'b0;
            o_conv_req        <= 1'b0;
            o_col_idx         <= '0;
            o_row_idx         <= '0;
            o_frame_done      <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            o_ilb_send_enable <= 1'b0;
            o_win_shift       <= 1'b0;
            o_frame_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pend_vld) begin
                        r_state           <= S_ISSUE;
                        o_seq_byte        <= r_pend_byte;
                        o_ilb_send_enable <= 1'b1;
                        o_busy            <= 1'b1;
                    end else if (i_soft_clear) begin
                        o_col_idx <= '0;
                        o_row_idx <= '0;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_ILB;
                end
                S_WAIT_ILB: begin
                    if (w_br_rise) begin
                        r_state     <= S_SHIFT;
                        o_win_shift <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_win_ok) begin
                        r_state    <= S_CONV_REQ;
                        o_conv_req <= 1'b1;
                    end else begin
                        r_state      <= S_ADVANCE;
                        o_frame_done <= w_frame_end;
                    end
                end
                S_CONV_REQ: begin
                    if (i_conv_ack) begin
                        r_state      <= S_ADVANCE;
                        o_conv_req   <= 1'b0;
                        o_frame_done <= w_frame_end;
                    end
                end
                S_ADVANCE: begin
                    if (o_col_idx == COL_LAST) begin
                        o_col_idx <= '0;
                        o_row_idx <= (o_row_idx == ROW_LAST) ? '0 : o_row_idx + IDX_W'(1);
                    end else begin
                        o_col_idx <= o_col_idx + IDX_W'(1);
                    end
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    o_conv_req <= 1'b0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ilb_pixel_sequencer.sv
// tb/tb_ilb_pixel_sequencer.sv - self-checking bench for ilb_pixel_sequencer on a 4x4 image
module tb_ilb_pixel_sequencer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_clear = 1'b0;
    logic          uart_valid = 1'b0;
    logic [7:0]    uart_byte = 8'd0;
    logic          br = 1'b0;
    logic          conv_ack = 1'b0;
    logic [7:0]    seq_byte;
    logic          ilb_send_enable;
    logic          win_shift;
    logic          conv_req;
    logic [IW-1:0] col_idx;
    logic [IW-1:0] row_idx;
    logic          frame_done;
    logic          busy;
    logic          overrun;

    ilb_pixel_sequencer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .KERNEL    (K),
        .IDX_W     (IW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_soft_clear     (soft_clear),
        .i_uart_valid     (uart_valid),
        .i_uart_byte_in   (uart_byte),
        .o_seq_byte       (seq_byte),
        .o_ilb_send_enable(ilb_send_enable),
        .i_bytes_recieved (br),
        .o_win_shift      (win_shift),
        .o_conv_req       (conv_req),
        .i_conv_ack       (conv_ack),
        .o_col_idx        (col_idx),
        .o_row_idx        (row_idx),
        .o_frame_done     (frame_done),
        .o_busy           (busy),
        .o_overrun        (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ILB interface model: answers each send strobe with a 2-cycle bytes_recieved pulse.
    int ilb_delay = 1;
    int br_rise_cyc = 0;
    always begin
        @(negedge clk);
        if (ilb_send_enable) begin
            repeat (ilb_delay) @(negedge clk);
            br = 1'b1;
            br_rise_cyc = cyc;
            @(negedge clk);
            @(negedge clk);
            br = 1'b0;
        end
    end

    int ack_delay = 1;
    int stray_cnt = 0;
    int stray_done = 0;
    always begin
        @(negedge clk);
        if (stray_cnt != stray_done) begin
            stray_done++;
            conv_ack = 1'b1;
            @(negedge clk);
            conv_ack = 1'b0;
        end else if (conv_req) begin
            repeat (ack_delay) @(negedge clk);
            conv_ack = 1'b1;
            @(negedge clk);
            conv_ack = 1'b0;
        end
    end

    logic [7:0] sent_q [512];
    int conv_c [64];
    int conv_r [64];
    int n_send = 0, n_shift = 0, n_conv = 0, n_frame = 0;
    int send_cyc = 0, shift_cyc = 0, req_rise = 0, req_fall = 0, idle_cyc = 0;
    logic prev_req = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (ilb_send_enable) begin
            sent_q[n_send % 512] = seq_byte;
            send_cyc = cyc;
            n_send++;
        end
        if (win_shift) begin
            n_shift++;
            shift_cyc = cyc;
        end
        if (conv_req && !prev_req) begin
            conv_c[n_conv % 64] = int'(col_idx);
            conv_r[n_conv % 64] = int'(row_idx);
            n_conv++;
            req_rise = cyc;
        end
        if (!conv_req && prev_req) req_fall = cyc;
        if (frame_done) n_frame++;
        if (!busy && prev_busy) idle_cyc = cyc;
        prev_req  = conv_req;
        prev_busy = busy;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_px(input logic [7:0] b, output int c);
        c = cyc;
        uart_byte  = b;
        uart_valid = 1'b1;
        tick();
        uart_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!busy && n < budget) begin tick(); n++; end
        while (busy && n < budget) begin tick(); n++; end
        chk("txn_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [7:0] px;
        int         col;
        int         row;
        int         conv;
        int         frame;
    } vec_t;

    vec_t tbl [W*H];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, s0, sh0, cv0, fr0, n, k, pos, exp_conv, exp_frame, b;
        logic [7:0] exp_bytes [64];
        int exp_cc [64];
        int exp_cr [64];

        for (int i = 0; i < W*H; i++) begin
            tbl[i].px    = 8'(8'h40 + i * 7);
            tbl[i].col   = i % W;
            tbl[i].row   = i / W;
            tbl[i].conv  = (tbl[i].col >= K-1 && tbl[i].row >= K-1) ? 1 : 0;
            tbl[i].frame = (i == W*H-1) ? 1 : 0;
        end

        repeat (3) tick();
        chk("rst_seq_byte", 32'(seq_byte), 0);
        chk("rst_send_en", 32'(ilb_send_enable), 0);
        chk("rst_win_shift", 32'(win_shift), 0);
        chk("rst_conv_req", 32'(conv_req), 0);
        chk("rst_col", 32'(col_idx), 0);
        chk("rst_row", 32'(row_idx), 0);
        chk("rst_frame", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // latency of a single idle pixel
        ilb_delay = 3;
        ack_delay = 1;
        s0 = n_send; sh0 = n_shift;
        send_px(8'hA5, c);
        wait_done(100);
        chk("lat_send", send_cyc - c, 2);
        chk("lat_byte", 32'(sent_q[s0 % 512]), 'hA5);
        chk("seq_hold", 32'(seq_byte), 'hA5);
        chk("one_send", n_send - s0, 1);
        chk("one_shift", n_shift - sh0, 1);
        chk("shift_lat", shift_cyc - br_rise_cyc, 2);
        chk("idle_lat", idle_cyc - br_rise_cyc, 4);
        chk("col_adv", 32'(col_idx), 1);

        // reset in the middle of WAIT_ILB
        ilb_delay = 30;
        send_px(8'h3C, c);
        repeat (4) tick();
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_seq", 32'(seq_byte), 0);
        chk("mid_rst_col", 32'(col_idx), 0);
        chk("mid_rst_send", 32'(ilb_send_enable), 0);
        s0 = n_send; sh0 = n_shift;
        rst_n = 1'b1;
        repeat (40) tick();
        chk("post_rst_sends", n_send - s0, 0);
        chk("post_rst_shifts", n_shift - sh0, 0);
        chk("post_rst_busy", 32'(busy), 0);

        // full 4x4 frame from the vector table
        ilb_delay = 1;
        ack_delay = 1;
        cv0 = n_conv; fr0 = n_frame;
        for (int i = 0; i < W*H; i++) begin
            int sv, cvv, frv;
            sv = n_send; cvv = n_conv; frv = n_frame;
            send_px(tbl[i].px, c);
            wait_done(100);
            chk($sformatf("frm_byte_%0d", i), 32'(sent_q[sv % 512]), 32'(tbl[i].px));
            chk($sformatf("frm_conv_%0d", i), n_conv - cvv, tbl[i].conv);
            if (tbl[i].conv != 0) begin
                chk($sformatf("frm_ccol_%0d", i), conv_c[cvv % 64], tbl[i].col);
                chk($sformatf("frm_crow_%0d", i), conv_r[cvv % 64], tbl[i].row);
            end
            chk($sformatf("frm_done_%0d", i), n_frame - frv, tbl[i].frame);
            chk($sformatf("frm_col_%0d", i), 32'(col_idx), ((i + 1) % (W*H)) % W);
            chk($sformatf("frm_row_%0d", i), 32'(row_idx), ((i + 1) % (W*H)) / W);
        end
        chk("frm_total_conv", n_conv - cv0, 4);
        chk("frm_first_col", conv_c[cv0 % 64], 2);
        chk("frm_first_row", conv_r[cv0 % 64], 2);
        chk("frm_total_done", n_frame - fr0, 1);

        // overrun while the interface is stalled
        ilb_delay = 15;
        s0 = n_send;
        send_px(8'h11, c);
        tick(); tick();
        send_px(8'h22, c);
        tick();
        send_px(8'h33, c);
        tick();
        send_px(8'h44, c);
        chk("ovr_set", 32'(overrun), 1);
        wait_done(100);
        wait_done(100);
        chk("ovr_sends", n_send - s0, 2);
        chk("ovr_byte0", 32'(sent_q[s0 % 512]), 'h11);
        chk("ovr_byte1", 32'(sent_q[(s0 + 1) % 512]), 'h22);
        send_px(8'h55, c);
        repeat (3) tick();
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
        chk("ovr_busy_clear", 32'(overrun), 1);
        wait_done(100);
        chk("col_before_clear", 32'(col_idx), 3);
        soft_clear = 1'b1;
        tick();
        soft_clear = 1'b0;
        chk("ovr_idle_clear", 32'(overrun), 0);
        chk("clear_col", 32'(col_idx), 0);
        chk("clear_row", 32'(row_idx), 0);

        // byte arriving in the ISSUE cycle
        ilb_delay = 2;
        s0 = n_send;
        send_px(8'h66, c);
        tick();
        chk("issue_now", 32'(ilb_send_enable), 1);
        send_px(8'h77, c);
        wait_done(100);
        wait_done(100);
        chk("coin_overrun", 32'(overrun), 0);
        chk("coin_sends", n_send - s0, 2);
        chk("coin_byte0", 32'(sent_q[s0 % 512]), 'h66);
        chk("coin_byte1", 32'(sent_q[(s0 + 1) % 512]), 'h77);

        // slow conv_ack and a stray ack while idle
        pulse_reset();
        ilb_delay = 1;
        ack_delay = 1;
        for (int i = 0; i < 10; i++) begin
            send_px(8'(i), c);
            wait_done(100);
        end
        ack_delay = 20;
        cv0 = n_conv;
        send_px(8'h99, c);
        n = 0;
        while (!conv_req && n < 50) begin tick(); n++; end
        chk("hold_req_seen", 32'(conv_req), 1);
        repeat (15) tick();
        chk("hold_req", 32'(conv_req), 1);
        chk("hold_col", 32'(col_idx), 2);
        chk("hold_row", 32'(row_idx), 2);
        chk("hold_busy", 32'(busy), 1);
        wait_done(100);
        chk("hold_nconv", n_conv - cv0, 1);
        chk("hold_len", req_fall - req_rise, 21);
        chk("hold_col_after", 32'(col_idx), 3);
        stray_cnt++;
        repeat (5) tick();
        chk("stray_busy", 32'(busy), 0);
        chk("stray_req", 32'(conv_req), 0);
        chk("stray_col", 32'(col_idx), 3);
        chk("stray_nconv", n_conv - cv0, 1);

        // randomized pixel stream against a raster-position model
        pulse_reset();
        s0 = n_send; cv0 = n_conv; fr0 = n_frame;
        exp_conv = 0; exp_frame = 0;
        for (k = 0; k < 45; k++) begin
            b = int'($urandom_range(0, 255));
            ilb_delay = int'($urandom_range(1, 4));
            ack_delay = int'($urandom_range(0, 5));
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 3) == 0) begin
                stray_cnt++;
                repeat (3) tick();
            end
            exp_bytes[k] = 8'(b);
            pos = k % (W*H);
            if ((pos % W) >= K-1 && (pos / W) >= K-1) begin
                exp_cc[exp_conv] = pos % W;
                exp_cr[exp_conv] = pos / W;
                exp_conv++;
            end
            if (pos == W*H-1) exp_frame++;
            send_px(8'(b), c);
            wait_done(100);
        end
        chk("rnd_sends", n_send - s0, 45);
        for (int i = 0; i < 45; i++)
            chk($sformatf("rnd_byte_%0d", i), 32'(sent_q[(s0 + i) % 512]), 32'(exp_bytes[i]));
        chk("rnd_nconv", n_conv - cv0, exp_conv);
        for (int i = 0; i < exp_conv; i++) begin
            chk($sformatf("rnd_ccol_%0d", i), conv_c[(cv0 + i) % 64], exp_cc[i]);
            chk($sformatf("rnd_crow_%0d", i), conv_r[(cv0 + i) % 64], exp_cr[i]);
        end
        chk("rnd_frames", n_frame - fr0, exp_frame);
        chk("rnd_col", 32'(col_idx), (45 % (W*H)) % W);
        chk("rnd_row", 32'(row_idx), (45 % (W*H)) / W);
        chk("rnd_overrun", 32'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
